// File: rtl/fb_swap_ctrl_pkg.sv
// ============================================================================
//  Module      : fb_ctrl_pkg
//  Description : Shared types and frame-buffer geometry for fb_swap_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_ctrl_pkg;

    typedef enum logic [1:0] {
        FB_CLEAR     = 2'd0,
        FB_RENDER    = 2'd1,
        FB_WAIT_SWAP = 2'd2
    } fb_state_t;

    localparam int FB_W     = 320;
    localparam int FB_H     = 180;
    localparam int FB_DEPTH = FB_W * FB_H;

    localparam logic [15:0] CLEAR_COLOR = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/fb_swap_ctrl_if.sv
// ============================================================================
//  Module      : fb_swap_ctrl_if
//  Description : Renderer/video-side port bundle of the double-buffer sequencer.
//                Optional statistics outputs present when FB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_swap_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int COLOR_W = 16
);
    logic               nf_in;
    logic               pix_valid_in;
    logic [ADDR_W-1:0]  pix_addr_in;
    logic [COLOR_W-1:0] pix_color_in;
    logic               render_done_in;
    logic               render_start_out;
    logic               front_sel_out;
    logic               we0_out;
    logic               we1_out;
    logic [ADDR_W-1:0]  waddr_out;
    logic [COLOR_W-1:0] wdata_out;
    logic               busy_out;
`ifdef FB_STATS_EN
    logic [15:0]        frame_miss_out;
    logic [15:0]        drop_cnt_out;
`endif

    modport slave (
        input  nf_in, pix_valid_in, pix_addr_in, pix_color_in, render_done_in,
        output render_start_out, front_sel_out, we0_out, we1_out,
               waddr_out, wdata_out, busy_out
`ifdef FB_STATS_EN
             , frame_miss_out, drop_cnt_out
`endif
    );

    modport master (
        output nf_in, pix_valid_in, pix_addr_in, pix_color_in, render_done_in,
        input  render_start_out, front_sel_out, we0_out, we1_out,
               waddr_out, wdata_out, busy_out
`ifdef FB_STATS_EN
             , frame_miss_out, drop_cnt_out
`endif
    );

endinterface

`default_nettype wire

// File: rtl/fb_swap_ctrl_clear_sweep.sv
// ============================================================================
//  Module      : fb_clear_sweep
//  Description : Address sweeper for the back-buffer clear; one word per step,
//                wraps to 0 after the last address and pulses done a cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_clear_sweep #(
    parameter int DEPTH  = 57600,
    parameter int ADDR_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              step,
    output logic [ADDR_W-1:0]      addr,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              w_last;

    assign w_last = (r_addr == c_last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= step && w_last;
            if (step) begin
                r_addr <= w_last ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign addr = r_addr;
    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
// ============================================================================
//  Module      : fb_swap_ctrl
//  Description : Double-buffer sequencer: clears the back buffer, grants it to
//                the renderer, swaps on new-frame. Optional FB_STATS_EN counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_swap_ctrl #(
    parameter int                 FB_DEPTH    = fb_ctrl_pkg::FB_DEPTH,
    parameter int                 ADDR_W      = 16,
    parameter int                 COLOR_W     = 16,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(fb_ctrl_pkg::CLEAR_COLOR)
) (
    input  wire logic      clk_in,
    input  wire logic      rst_in,
    fb_swap_ctrl_if.slave  bus
);
    import fb_ctrl_pkg::*;

    localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(FB_DEPTH);

    fb_state_t          r_state;
    fb_state_t          w_next_state;
    logic               r_front;
    logic               r_we0;
    logic               r_we1;
    logic [ADDR_W-1:0]  r_waddr;
    logic [COLOR_W-1:0] r_wdata;
    logic               r_start;
    logic               r_busy;

    logic [ADDR_W-1:0]  w_clr_addr;
    logic               w_sweep_done;
    logic               w_in_range;
    logic               w_pix_wr;
    logic               w_swap;
    logic               w_clr_step;
    logic               w_wr;
    logic               w_next_front;
    logic               w_sel;
    logic               w_start;

    fb_clear_sweep #(
        .DEPTH  (FB_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk  (clk_in),
        .rst  (rst_in),
        .step (w_clr_step),
        .addr (w_clr_addr),
        .done (w_sweep_done)
    );

    assign w_in_range = ({1'b0, bus.pix_addr_in} < c_depth_ext);
    assign w_pix_wr   = (r_state == FB_RENDER) && bus.pix_valid_in && w_in_range;
    assign w_swap     = bus.nf_in && ((r_state == FB_WAIT_SWAP) ||
                                      ((r_state == FB_RENDER) && bus.render_done_in));
    // The swap cycle itself issues the first clear word, unless a renderer
    // write already owns the write port that cycle.
    assign w_clr_step = ((r_state == FB_CLEAR) && !w_sweep_done) || (w_swap && !w_pix_wr);
    assign w_wr         = w_pix_wr || w_clr_step;
    assign w_next_front = w_swap ? ~r_front : r_front;
    assign w_sel        = w_pix_wr ? ~r_front : ~w_next_front;
    assign w_start      = (r_state == FB_CLEAR) && w_sweep_done;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FB_CLEAR: begin
                if (w_sweep_done) w_next_state = FB_RENDER;
            end
            FB_RENDER: begin
                if (bus.render_done_in) w_next_state = bus.nf_in ? FB_CLEAR : FB_WAIT_SWAP;
            end
            FB_WAIT_SWAP: begin
                if (bus.nf_in) w_next_state = FB_CLEAR;
            end
            default: w_next_state = FB_CLEAR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= FB_CLEAR;
            r_front <= 1'b0;
            r_we0   <= 1'b0;
            r_we1   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_front <= w_next_front;
            r_we0   <= w_wr && !w_sel;
            r_we1   <= w_wr && w_sel;
            if (w_wr) begin
                r_waddr <= w_pix_wr ? bus.pix_addr_in  : w_clr_addr;
                r_wdata <= w_pix_wr ? bus.pix_color_in : CLEAR_COLOR;
            end
            r_start <= w_start;
            r_busy  <= (w_next_state != FB_WAIT_SWAP);
        end
    end

    assign bus.render_start_out = r_start;
    assign bus.front_sel_out    = r_front;
    assign bus.we0_out          = r_we0;
    assign bus.we1_out          = r_we1;
    assign bus.waddr_out        = r_waddr;
    assign bus.wdata_out        = r_wdata;
    assign bus.busy_out         = r_busy;

`ifdef FB_STATS_EN
    logic [15:0] r_frame_miss;
    logic [15:0] r_drop_cnt;
    logic        w_miss;
    logic        w_drop;

    assign w_miss = bus.nf_in && ((r_state == FB_CLEAR) ||
                                  ((r_state == FB_RENDER) && !bus.render_done_in));
    assign w_drop = bus.pix_valid_in && !w_pix_wr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame_miss <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_miss && (r_frame_miss != 16'hFFFF)) r_frame_miss <= r_frame_miss + 16'd1;
            if (w_drop && (r_drop_cnt   != 16'hFFFF)) r_drop_cnt   <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.frame_miss_out = r_frame_miss;
    assign bus.drop_cnt_out   = r_drop_cnt;
`endif

endmodule

`default_nettype wire
